// File: rtl/argmax_classifier.sv
// Reduces a captured fixed-point score vector to the index and value of its maximum,
// using one signed comparator stepped across the vector, one element per clock.
package argmax_classifier_pkg;
  localparam int unsigned INT_WIDTH  = 8;
  localparam int unsigned FRAC_WIDTH = 8;
  localparam int unsigned FP_WIDTH   = INT_WIDTH + FRAC_WIDTH;

  typedef struct packed {
    logic [INT_WIDTH-1:0]  integral;
    logic [FRAC_WIDTH-1:0] fraction;
  } fixed_point;
endpackage

module argmax_classifier
  import argmax_classifier_pkg::*;
#(
  parameter  int unsigned NUM_CLASSES = 10,
  localparam int unsigned INDEX_WIDTH = $clog2(NUM_CLASSES)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  fixed_point             scores [NUM_CLASSES],
  input  logic                   scores_ready,
  output logic [INDEX_WIDTH-1:0] class_index,
  output fixed_point             max_score,
  output logic                   class_valid,
  output logic                   busy
);

  if (NUM_CLASSES < 2) begin : g_bad_num_classes
    $error("argmax_classifier: NUM_CLASSES must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                 state;
  fixed_point             vec_q [NUM_CLASSES];
  fixed_point             best_q;
  logic [INDEX_WIDTH-1:0] best_idx_q;
  logic [INDEX_WIDTH-1:0] idx_q;
  logic                   ready_q;

  logic signed [FP_WIDTH-1:0] cand_c;
  logic signed [FP_WIDTH-1:0] best_c;
  logic                       cand_gt_c;
  fixed_point                 next_best_c;
  logic [INDEX_WIDTH-1:0]     next_idx_c;

  // Strict signed compare keeps the lowest index among equal maxima.
  assign cand_c      = vec_q[idx_q];
  assign best_c      = best_q;
  assign cand_gt_c   = cand_c > best_c;
  assign next_best_c = cand_gt_c ? vec_q[idx_q] : best_q;
  assign next_idx_c  = cand_gt_c ? idx_q : best_idx_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      best_q      <= '0;
      best_idx_q  <= '0;
      idx_q       <= '0;
      ready_q     <= 1'b1;
      class_index <= '0;
      max_score   <= '0;
      class_valid <= 1'b0;
      busy        <= 1'b0;
      for (int j = 0; j < int'(NUM_CLASSES); j++) vec_q[j] <= '0;
    end else begin
      ready_q     <= scores_ready;
      class_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Only a fresh rising edge of scores_ready starts a capture.
          if (scores_ready && !ready_q) begin
            for (int j = 0; j < int'(NUM_CLASSES); j++) vec_q[j] <= scores[j];
            best_q     <= scores[0];
            best_idx_q <= '0;
            idx_q      <= INDEX_WIDTH'(1);
            busy       <= 1'b1;
            state      <= SCAN;
          end
        end
        SCAN: begin
          best_q     <= next_best_c;
          best_idx_q <= next_idx_c;
          idx_q      <= idx_q + INDEX_WIDTH'(1);
          if (idx_q == INDEX_WIDTH'(NUM_CLASSES - 1)) begin
            class_index <= next_idx_c;
            max_score   <= next_best_c;
            class_valid <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed and randomized checks of argmax_classifier against a two-pass
// max-then-first-index reference model.
module tb_argmax_classifier;
  import argmax_classifier_pkg::*;

  localparam int unsigned N  = 10;
  localparam int unsigned IW = $clog2(N);

  logic          clock = 1'b0;
  logic          reset;
  fixed_point    scores [N];
  logic          scores_ready;
  logic [IW-1:0] class_index;
  fixed_point    max_score;
  logic          class_valid;
  logic          busy;

  int compared   = 0;
  int mismatched = 0;

  fixed_point vec [N];

  argmax_classifier #(.NUM_CLASSES(N)) dut (
    .clock(clock),
    .reset(reset),
    .scores(scores),
    .scores_ready(scores_ready),
    .class_index(class_index),
    .max_score(max_score),
    .class_valid(class_valid),
    .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic fixed_point fp(input int q);
    return fixed_point'(16'(q));
  endfunction

  function automatic int sval(input fixed_point f);
    logic signed [15:0] t;
    t = f;
    return int'(t);
  endfunction

  // Reference: find the maximum value, then the first index holding it.
  task automatic model(output int exp_idx, output fixed_point exp_max);
    int mx;
    mx = sval(vec[0]);
    for (int j = 1; j < int'(N); j++) if (sval(vec[j]) > mx) mx = sval(vec[j]);
    exp_idx = -1;
    for (int j = 0; j < int'(N); j++) if (exp_idx < 0 && sval(vec[j]) == mx) exp_idx = j;
    exp_max = fp(mx);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drop then raise scores_ready, watch the scan, and check timing and result.
  task automatic run_scan(input string tag, input bit mutate);
    int first_k = -1;
    int nvalid  = 0;
    int nbusy   = 0;
    int exp_idx;
    fixed_point exp_max;
    model(exp_idx, exp_max);
    @(negedge clock);
    for (int j = 0; j < int'(N); j++) scores[j] = vec[j];
    scores_ready = 1'b0;
    @(negedge clock);
    scores_ready = 1'b1;
    for (int k = 1; k <= int'(N) + 4; k++) begin
      @(negedge clock);
      if (mutate && k == 1) scores[8] = fp(16'h7f00);
      if (class_valid) begin
        nvalid++;
        if (first_k < 0) first_k = k;
      end
      if (busy) nbusy++;
    end
    check({tag, "_latency"}, 32'(first_k), 32'(N));
    check({tag, "_valid_count"}, 32'(nvalid), 32'd1);
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'(N - 1));
    check({tag, "_index"}, 32'(class_index), 32'(exp_idx));
    check({tag, "_score"}, {16'h0, max_score}, {16'h0, exp_max});
  endtask

  initial begin
    int nvalid;
    int nbusy;
    int a;
    int b;

    reset        = 1'b1;
    scores_ready = 1'b1;
    for (int j = 0; j < int'(N); j++) begin
      scores[j] = '0;
      vec[j]    = '0;
    end
    repeat (3) @(negedge clock);
    check("reset_index", 32'(class_index), 32'd0);
    check("reset_score", {16'h0, max_score}, 32'd0);
    check("reset_valid", 32'(class_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // scores_ready already high at release must not capture
    reset = 1'b0;
    nbusy = 0;
    repeat (12) begin
      @(negedge clock);
      if (busy || class_valid) nbusy++;
    end
    check("no_capture_when_high_at_release", 32'(nbusy), 32'd0);

    // Ascending ramp 0.1 .. 1.0
    for (int j = 0; j < int'(N); j++) vec[j] = fp($rtoi(real'(j + 1) * 25.6 + 0.5));
    run_scan("ramp", 1'b0);

    // Max at index 0, then at index 4
    for (int j = 0; j < int'(N); j++) vec[j] = fp(26);
    vec[0] = fp(230);
    run_scan("max_at_0", 1'b0);
    vec[0] = fp(26);
    vec[4] = fp(230);
    run_scan("max_at_4", 1'b0);

    // Tie between indices 2 and 7
    for (int j = 0; j < int'(N); j++) vec[j] = fp(64);
    vec[2] = fp(192);
    vec[7] = fp(192);
    run_scan("tie", 1'b0);

    // All negative
    for (int j = 0; j < int'(N); j++) vec[j] = fp(-128);
    vec[5] = fp(-32);
    run_scan("negative", 1'b0);

    // Upstream change after capture is ignored
    for (int j = 0; j < int'(N); j++) vec[j] = fp($rtoi(real'(j + 1) * 25.6 + 0.5));
    run_scan("mutate", 1'b1);

    // Held high: no further result
    nvalid = 0;
    repeat (30) begin
      @(negedge clock);
      if (class_valid) nvalid++;
    end
    check("held_high_no_retrigger", 32'(nvalid), 32'd0);

    // Fresh rising edge gives a second result
    vec[3] = fp(1000);
    run_scan("retrigger", 1'b0);

    // Reset mid-scan
    @(negedge clock);
    scores_ready = 1'b0;
    @(negedge clock);
    scores_ready = 1'b1;
    repeat (5) @(negedge clock);
    check("busy_before_abort", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_index", 32'(class_index), 32'd0);
    check("abort_score", {16'h0, max_score}, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    nvalid = 0;
    nbusy  = 0;
    repeat (20) begin
      @(negedge clock);
      if (class_valid) nvalid++;
      if (busy) nbusy++;
    end
    check("abort_no_valid", 32'(nvalid), 32'd0);
    check("abort_no_recapture", 32'(nbusy), 32'd0);
    run_scan("after_abort", 1'b0);

    // Randomized vectors, some narrowed to force ties
    for (int r = 0; r < 12; r++) begin
      for (int j = 0; j < int'(N); j++)
        vec[j] = (r % 3 == 0) ? fp(int'($urandom_range(0, 3)) - 2) : fp(int'($urandom));
      a = int'($urandom_range(0, N - 1));
      b = int'($urandom_range(0, N - 1));
      if (r % 2 == 1) vec[b] = vec[a];
      run_scan($sformatf("rand%0d", r), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/argmax_classifier.md
Name: argmax_classifier

Overview:
- Downstream consumer of neural_network: takes the final-layer score vector (outputs / outputs_ready) and reduces it to a predicted class index plus its winning score.
- Scans the captured vector sequentially, one comparison per clock, so a single comparator serves any NUM_CLASSES.
- Result feeds board-level display/UART logic as a registered index with a one-cycle valid pulse.

Parameters:
- NUM_CLASSES, 10, number of scores; must equal the last layer SIZE; elaboration assertion requires >= 2.
- INDEX_WIDTH, $clog2(NUM_CLASSES), width of class_index; derived, not overridden.

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- scores  input  fixed_point[NUM_CLASSES]  score vector, connected to neural_network outputs.
- scores_ready  input  1  level signal, connected to neural_network outputs_ready.
- class_index  output  INDEX_WIDTH  index of the maximum score of the last completed scan.
- max_score  output  fixed_point  value of that maximum score.
- class_valid  output  1  one-cycle pulse when class_index/max_score update.
- busy  output  1  high while a capture/scan is in progress.

Behaviour:
- Reset values: class_index=0, max_score=0, class_valid=0, busy=0, state=IDLE, index counter=0, ready_q=1.
  - ready_q=1 at reset means a capture requires scores_ready to be seen low at least once after reset.
- Trigger: in IDLE, at an edge where scores_ready=1 and ready_q=0 (rising edge of scores_ready):
  - copy all NUM_CLASSES scores into an internal register array;
  - best<=scores[0], best_idx<=0, i<=1, state<=SCAN, busy<=1.
- ready_q<=scores_ready on every edge, in every state.
- SCAN: each edge compares reg[i] against best.
  - Comparison is signed two's complement on the concatenated {integral,fraction} bits.
  - If reg[i] > best (strict), best<=reg[i] and best_idx<=i.
  - i<=i+1.
- Scan completion: at the edge where i==NUM_CLASSES-1, the compare above is folded into the outputs:
  - class_index<=final best_idx, max_score<=final best;
  - class_valid<=1, busy<=0, state<=DONE.
- DONE lasts one cycle: class_valid<=0, state<=IDLE.
- Latency: capture at edge E0; class_valid is high in the cycle after edge E0+NUM_CLASSES-1 (NUM_CLASSES=10: high after the 9th edge following capture), for exactly one cycle.
- class_index and max_score hold their value until the next completed scan.
- Ties: strict greater-than, so the lowest index among equal maxima wins.
- Upstream changes during a scan: scans use the captured copy, so changes on scores after E0 have no effect.
- scores_ready is edge-triggered only:
  - held high, it causes no re-trigger;
  - a rising edge during SCAN or DONE is ignored, but ready_q still tracks, so that edge is lost;
  - the next trigger needs a fresh rising edge while in IDLE.
- Minimum spacing between results: NUM_CLASSES+1 cycles.
- Reset mid-scan: abort immediately; outputs return to reset values and no class_valid pulse is produced for the aborted vector.
- All-negative or all-zero vectors: the result is still well-defined (maximum or index 0); no special casing.

Test Plan:
- Rising edge of scores_ready, scores = 0.1, 0.2, …, 1.0 (index 9 largest) -> class_valid pulses exactly once, 9 edges after capture; class_index=9, max_score=1.0; busy high for 9 cycles.
- Maximum at index 0 (0.9, others 0.1) -> class_index=0, max_score=0.9; and maximum at index 4 -> class_index=4.
- Tie: indices 2 and 7 both 0.75, others 0.25 -> class_index=2, max_score=0.75.
- Signed compare: all scores negative, index 5 = -0.125, others -0.5 -> class_index=5, max_score=-0.125.
- Mutation and re-trigger:
  - change scores to make index 8 largest one cycle after capture -> result reflects the captured vector, not index 8;
  - scores_ready held high for 30 cycles -> exactly one class_valid;
  - drop scores_ready, then raise it again -> second result.
- Reset edge cases:
  - assert reset mid-SCAN (edge E0+4) -> all outputs 0 immediately and no class_valid;
  - scores_ready already high at reset release -> no capture until it goes low then high.
